// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU and its debug run controller.
package cpu_pkg;

    localparam int unsigned c_ADDR_W = 8;
    localparam int unsigned c_CNT_W  = 16;

    // Run-controller states; encoding is visible on o_state.
    typedef enum logic [1:0] {
        s_HALT  = 2'b00,
        s_RUN   = 2'b01,
        s_STEP  = 2'b10,
        s_DRAIN = 2'b11
    } state_e;

endpackage : cpu_pkg

// File: rtl/bp_compare.sv
// PC breakpoint comparator: purely combinational equality match with enable.
module bp_compare
    import cpu_pkg::*;
#(
    parameter int unsigned g_ADDR_W = c_ADDR_W
) (
    input  logic                i_en,
    input  logic [g_ADDR_W-1:0] i_pc,
    input  logic [g_ADDR_W-1:0] i_bp_addr,
    output logic                o_match_c
);

    // Match only when the breakpoint is armed.
    assign o_match_c = i_en && (i_pc == i_bp_addr);

endmodule : bp_compare

// File: rtl/debug_run_controller.sv
// Run/halt/single-step sequencer producing the CPU core clock-enable.
// Optional PC breakpoint is compiled in when DEBUG_BP_EN is defined.
module debug_run_controller
    import cpu_pkg::*;
#(
    parameter int unsigned g_ADDR_W = c_ADDR_W,
    parameter int unsigned g_CNT_W  = c_CNT_W
) (
    input  logic                Clk,
    input  logic                reset,
    input  logic                i_run,
    input  logic                i_halt,
    input  logic                i_step,
    input  logic                i_fetch,
    input  logic [g_ADDR_W-1:0] i_pc,
    input  logic                i_bp_en,
    input  logic [g_ADDR_W-1:0] i_bp_addr,
    input  logic                i_cnt_clr,
    output logic                o_cpu_en,
    output logic [1:0]          o_state,
    output logic                o_bp_hit,
    output logic                o_step_done,
    output logic [g_CNT_W-1:0]  o_cycle_count
);

    state_e               state_q, state_d;
    logic                 cpu_en_q, cpu_en_d;
    logic                 bp_hit_q, bp_hit_d;
    logic                 step_done_q, step_done_d;
    logic [g_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 fetch_ev_c;
    logic                 bp_match_c;

    // A fetch only counts as an instruction boundary when the core actually ran it.
    assign fetch_ev_c = i_fetch && cpu_en_q;

`ifdef DEBUG_BP_EN
    bp_compare #(
        .g_ADDR_W (g_ADDR_W)
    ) u_bp_compare (
        .i_en      (i_bp_en),
        .i_pc      (i_pc),
        .i_bp_addr (i_bp_addr),
        .o_match_c (bp_match_c)
    );
`else
    logic unused_bp;
    assign unused_bp  = ^{i_bp_en, i_bp_addr};
    assign bp_match_c = 1'b0;
`endif

    // Next-state and pulse logic; stops always land right after a fetch event.
    always_comb begin
        state_d     = state_q;
        bp_hit_d    = 1'b0;
        step_done_d = 1'b0;
        case (state_q)
            s_HALT: begin
                if (i_run) begin
                    state_d = s_RUN;
                end else if (i_step) begin
                    state_d = s_STEP;
                end
            end
            s_RUN: begin
                if (fetch_ev_c && bp_match_c) begin
                    state_d  = s_HALT;
                    bp_hit_d = 1'b1;
                end else if (i_halt) begin
                    state_d = s_DRAIN;
                end
            end
            s_DRAIN: begin
                if (fetch_ev_c) begin
                    state_d  = s_HALT;
                    bp_hit_d = bp_match_c;
                end
            end
            s_STEP: begin
                if (fetch_ev_c) begin
                    state_d     = s_HALT;
                    step_done_d = 1'b1;
                end
            end
            default: state_d = s_HALT;
        endcase
        cpu_en_d = (state_d != s_HALT);
    end

    // Enabled-cycle counter; clear wins over increment, wraps naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (i_cnt_clr) begin
            cnt_d = '0;
        end else if (cpu_en_q) begin
            cnt_d = cnt_q + g_CNT_W'(1);
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q     <= s_HALT;
            cpu_en_q    <= 1'b0;
            bp_hit_q    <= 1'b0;
            step_done_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cpu_en_q    <= cpu_en_d;
            bp_hit_q    <= bp_hit_d;
            step_done_q <= step_done_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_cpu_en      = cpu_en_q;
    assign o_state       = state_q;
    assign o_bp_hit      = bp_hit_q;
    assign o_step_done   = step_done_q;
    assign o_cycle_count = cnt_q;

endmodule : debug_run_controller
